mod_n_time_counter: RTL and testbench
=====================================

Name: mod_n_time_counter

Overview:
- Parametrised modulo-N time-field counter for the digital clock: seconds, minutes, hours (24 or 12), days, or countdown fields.
- It is the next generation of the fixed mod-60 field counter and adds the following:
  - configurable modulus and width
  - run-mode count direction, for countdown timers
  - synchronous load
  - hold-to-auto-repeat for the manual up/down keys
- Instances chain carry_out into the next field's signal input.

Parameters:
MODULUS, 60, number of states; value range is 0..MODULUS-1 (MODULUS >= 2)
WIDTH, 6, width of value/load_value; must satisfy 2^WIDTH >= MODULUS
RESET_VALUE, 0, value after reset; must be < MODULUS
REPEAT_DELAY, 16, clk cycles from the first manual step to the first auto-repeat step (>= 2)
REPEAT_PERIOD, 4, clk cycles between consecutive auto-repeat steps (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
manual_set  input  1  1 = manual adjust mode (keys active, signal ignored)
up  input  1  manual increment key (level, synchronous, debounced upstream)
down  input  1  manual decrement key (level, synchronous, debounced upstream)
signal  input  1  run-mode step pulse (carry from the lower field or a tick), 1 cycle wide
count_dir  input  1  run-mode direction: 0 = up, 1 = down
load  input  1  synchronous load strobe
load_value  input  WIDTH  value to load
value  output  WIDTH  current count, registered
carry_out  output  1  1-cycle pulse on run-mode wrap, registered

Behaviour:
- Reset (async, rst_n=0):
  - value=RESET_VALUE, carry_out=0
  - repeat FSM=IDLE, repeat counter=0, key history registers=0
  - Reset mid-hold aborts the repeat; a still-held key after reset release counts as a new press only after it has first been sampled low.
- Default: carry_out=0 every cycle unless a run-mode wrap occurs.
- Priority per cycle: load > manual_set > signal.
- Wrap arithmetic (all steps): inc: MODULUS-1 -> 0, else +1; dec: 0 -> MODULUS-1, else -1. value is never >= MODULUS.
- load=1:
  - value <= load_value if load_value < MODULUS, else MODULUS-1 (clamp).
  - carry_out=0; repeat FSM -> IDLE; signal and keys ignored that cycle.
- Manual mode (manual_set=1, load=0):
  - Key request: inc if up&!down, dec if down&!up, none if both or neither. Both pressed = no step; FSM -> IDLE.
  - Press = request non-none and (request differs from the previous cycle's request, or FSM was IDLE).
  - IDLE: on press, step once at that edge, clear the repeat counter, go to DELAY.
  - DELAY: counter increments each cycle the same request is held. At the REPEAT_DELAY-th edge after the first step, step once, clear the counter, go to REPEAT.
  - REPEAT: step every REPEAT_PERIOD cycles while held.
  - Request changes to the other direction (clean switch): treat as a new press; step immediately in the new direction, then go to DELAY.
  - Release, or manual_set=0: FSM -> IDLE, no step.
  - Manual steps never assert carry_out. signal is ignored (dropped, not queued).
- Run mode (manual_set=0, load=0, signal=1):
  - count_dir=0: increment; on MODULUS-1 -> 0, carry_out=1 for exactly that cycle.
  - count_dir=1: decrement; on 0 -> MODULUS-1, carry_out=1 for exactly that cycle.
  - Latency: value and carry_out both update at the edge sampling signal=1; carry_out is high for the following cycle only.
- signal=0 and no load/manual activity: value holds.
- Back-to-back signal pulses on consecutive cycles each step (sustained rate 1/cycle is legal).

Test Plan:
- Reset/run wrap:
  - Stimulus: MODULUS=60, count_dir=0; rst_n low then high; 60 single-cycle signal pulses.
  - Response: value 0..59 then 0; carry_out high exactly once, on the cycle after the 59->0 edge.
- Countdown, MODULUS=24:
  - Stimulus: load 0, count_dir=1, one signal pulse.
  - Response: value=23, carry_out=1 for one cycle; next pulse gives 22, carry_out=0.
- Auto-repeat (REPEAT_DELAY=16, REPEAT_PERIOD=4, start value 10):
  - Stimulus: manual_set=1, up held for 30 cycles.
  - Response: 11 at the first edge, 12 at +16, then 13, 14, 15 at +20, +24, +28; release -> holds 15; carry_out never set.
- Manual boundaries:
  - Stimulus: value 0, down tap; then up tap at 59; then up&down held together 20 cycles.
  - Response: 0->59, 59->0, then no change; a 2-cycle signal pulse during manual_set is ignored.
- Load and clamp (MODULUS=60):
  - Stimulus: load_value=63 with load=1 and signal=1 in the same cycle.
  - Response: value=59, carry_out=0; load_value=7 -> 7.
- Reset mid-hold:
  - Stimulus: up held in REPEAT state; rst_n pulsed low while up stays high.
  - Response: value=RESET_VALUE; no step until up is released and re-pressed.

Source files
------------

// File: rtl/mod_n_time_counter.sv
// Modulo-N time-field counter: run-mode up/down stepping with wrap carry,
// synchronous clamped load, and manual keys with hold-to-auto-repeat.
module mod_n_time_counter #(
  parameter int MODULUS       = 60,
  parameter int WIDTH         = 6,
  parameter int RESET_VALUE   = 0,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             manual_set,
  input  logic             up,
  input  logic             down,
  input  logic             signal,
  input  logic             count_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_INC  = 2'd1,
    REQ_DEC  = 2'd2
  } req_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    if (v == MAX_VAL) begin
      return '0;
    end else begin
      return v + WIDTH'(1);
    end
  endfunction

  function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
    if (v == WIDTH'(0)) begin
      return MAX_VAL;
    end else begin
      return v - WIDTH'(1);
    end
  endfunction

  // Out-of-range load values saturate to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} < (WIDTH + 1)'(MODULUS)) begin
      return v;
    end else begin
      return MAX_VAL;
    end
  endfunction

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_e             prev_req_q;
  logic             up_arm_q, dn_arm_q;

  req_e             req_s;
  logic             press_s;
  logic             armed_s;
  logic [WIDTH-1:0] manual_step_s;

  // Decode the key pair into a single request and its press/arming status.
  always_comb begin
    req_s   = REQ_NONE;
    armed_s = 1'b0;
    if (up && !down) begin
      req_s = REQ_INC;
    end else if (down && !up) begin
      req_s = REQ_DEC;
    end else begin
      req_s = REQ_NONE;
    end
    case (req_s)
      REQ_INC: armed_s = up_arm_q;
      REQ_DEC: armed_s = dn_arm_q;
      default: armed_s = 1'b0;
    endcase
    press_s = (req_s != REQ_NONE) && ((req_s != prev_req_q) || (state_q == ST_IDLE));
    if (req_s == REQ_DEC) begin
      manual_step_s = dec_wrap(value_q);
    end else begin
      manual_step_s = inc_wrap(value_q);
    end
  end

  // Next-state logic: load beats manual mode, manual mode beats run-mode steps.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      value_d = clamp_load(load_value);
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (manual_set) begin
      if (req_s == REQ_NONE) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (press_s) begin
        // A key held through reset stays locked out until it is seen released.
        if (armed_s) begin
          value_d = manual_step_s;
          state_d = ST_DELAY;
        end else begin
          state_d = ST_IDLE;
        end
        cnt_d = '0;
      end else begin
        case (state_q)
          ST_DELAY: begin
            if (cnt_q == DELAY_LAST) begin
              value_d = manual_step_s;
              state_d = ST_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (cnt_q == PERIOD_LAST) begin
              value_d = manual_step_s;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (signal) begin
        if (count_dir) begin
          value_d = dec_wrap(value_q);
          carry_d = (value_q == WIDTH'(0));
        end else begin
          value_d = inc_wrap(value_q);
          carry_d = (value_q == MAX_VAL);
        end
      end else begin
        value_d = value_q;
      end
    end
  end

  // State, count and key-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= RST_VAL;
      carry_q    <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      prev_req_q <= REQ_NONE;
      up_arm_q   <= 1'b0;
      dn_arm_q   <= 1'b0;
    end else begin
      value_q    <= value_d;
      carry_q    <= carry_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_req_q <= req_s;
      up_arm_q   <= up_arm_q | ~up;
      dn_arm_q   <= dn_arm_q | ~down;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_mod_n_time_counter.sv
// Directed bench for mod_n_time_counter: a mod-60 field and a mod-24 countdown field.
module tb_mod_n_time_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       manual_set = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       signal = 1'b0;
  logic       count_dir = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_value = 6'd0;
  logic [5:0] value;
  logic       carry_out;

  logic       load24 = 1'b0;
  logic       signal24 = 1'b0;
  logic       dir24 = 1'b0;
  logic [4:0] lv24 = 5'd0;
  logic [4:0] value24;
  logic       carry24;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_n_time_counter #(.MODULUS(60), .WIDTH(6), .RESET_VALUE(0),
                       .REPEAT_DELAY(16), .REPEAT_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .manual_set(manual_set), .up(up), .down(down),
    .signal(signal), .count_dir(count_dir), .load(load), .load_value(load_value),
    .value(value), .carry_out(carry_out)
  );

  mod_n_time_counter #(.MODULUS(24), .WIDTH(5), .RESET_VALUE(0),
                       .REPEAT_DELAY(16), .REPEAT_PERIOD(4)) dut24 (
    .clk(clk), .rst_n(rst_n), .manual_set(1'b0), .up(1'b0), .down(1'b0),
    .signal(signal24), .count_dir(dir24), .load(load24), .load_value(lv24),
    .value(value24), .carry_out(carry24)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_v;

    // Reset state
    tick();
    tick();
    chk("rst_value", int'(value), 0);
    chk("rst_carry", int'(carry_out), 0);
    chk("rst_value24", int'(value24), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", int'(value), 0);

    // Back-to-back run-mode pulses through a full wrap
    count_dir = 1'b0;
    for (int i = 0; i < 60; i++) begin
      signal = 1'b1;
      tick();
      chk("run_value", int'(value), (i + 1) % 60);
      chk("run_carry", int'(carry_out), (i == 59) ? 1 : 0);
    end
    signal = 1'b0;
    tick();
    chk("run_carry_drop", int'(carry_out), 0);
    chk("run_hold", int'(value), 0);

    // Countdown on the mod-24 field
    load24 = 1'b1; lv24 = 5'd0;
    tick();
    load24 = 1'b0;
    chk("cd_load", int'(value24), 0);
    dir24 = 1'b1; signal24 = 1'b1;
    tick();
    chk("cd_wrap_value", int'(value24), 23);
    chk("cd_wrap_carry", int'(carry24), 1);
    tick();
    signal24 = 1'b0;
    chk("cd_next_value", int'(value24), 22);
    chk("cd_next_carry", int'(carry24), 0);

    // Load beats signal, with clamp
    load = 1'b1; load_value = 6'd63; signal = 1'b1;
    tick();
    signal = 1'b0;
    chk("clamp_value", int'(value), 59);
    chk("clamp_carry", int'(carry_out), 0);
    load_value = 6'd7;
    tick();
    chk("load_value", int'(value), 7);

    // Auto-repeat from 10
    load_value = 6'd10;
    tick();
    load = 1'b0;
    chk("ar_start", int'(value), 10);
    manual_set = 1'b1; up = 1'b1;
    tick();
    chk("ar_first", int'(value), 11);
    for (int k = 1; k < 30; k++) begin
      tick();
      exp_v = 11 + ((k >= 16) ? 1 : 0) + ((k >= 20) ? 1 : 0)
                 + ((k >= 24) ? 1 : 0) + ((k >= 28) ? 1 : 0);
      chk("ar_value", int'(value), exp_v);
      chk("ar_carry", int'(carry_out), 0);
    end
    up = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ar_release", int'(value), 15);
    end

    // Manual boundaries (load works in manual mode too)
    load = 1'b1; load_value = 6'd0;
    tick();
    load = 1'b0;
    down = 1'b1;
    tick();
    chk("man_dec_wrap", int'(value), 59);
    chk("man_dec_carry", int'(carry_out), 0);
    down = 1'b0;
    tick();
    up = 1'b1;
    tick();
    chk("man_inc_wrap", int'(value), 0);
    chk("man_inc_carry", int'(carry_out), 0);
    up = 1'b0;
    tick();
    up = 1'b1; down = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("man_both", int'(value), 0);
    end
    up = 1'b0; down = 1'b0;
    signal = 1'b1;
    tick();
    tick();
    signal = 1'b0;
    chk("man_signal_ignored", int'(value), 0);
    chk("man_signal_carry", int'(carry_out), 0);
    manual_set = 1'b0;
    tick();
    chk("run_after_manual", int'(value), 0);

    // Reset mid-hold
    load = 1'b1; load_value = 6'd20;
    tick();
    load = 1'b0;
    manual_set = 1'b1; up = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("mid_hold_value", int'(value), 22);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_value", int'(value), 0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("post_rst_locked", int'(value), 0);
    end
    up = 1'b0;
    tick();
    chk("post_rst_release", int'(value), 0);
    up = 1'b1;
    tick();
    chk("post_rst_repress", int'(value), 1);
    up = 1'b0;
    manual_set = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
